// File: rtl/led_mode_ctrl.sv
// LED mode controller: each qualified press steps the LED through OFF, ON,
// SLOW blink, FAST blink and BREATH (triangular PWM fade).
//
// state    | meaning
// M_OFF    | led held low
// M_ON     | led held high
// M_SLOW   | led toggles every slow_half cycles
// M_FAST   | led toggles every fast_half cycles
// M_BREATH | led = pwm_cnt < duty, duty ramps 0..max..0 every breath_step cycles
module led_mode_ctrl #(
    parameter int slow_half   = 25_000_000,
    parameter int fast_half   = 6_250_000,
    parameter int pwm_bits    = 8,
    parameter int breath_step = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       press,
    output logic       led,
    output logic [2:0] mode
);

    localparam int BLINK_MAX = (slow_half > fast_half) ? slow_half : fast_half;
    localparam int BW        = $clog2(BLINK_MAX + 1);
    localparam int SW        = $clog2(breath_step + 1);

    localparam logic [BW-1:0]       SLOW_TC  = BW'(slow_half - 1);
    localparam logic [BW-1:0]       FAST_TC  = BW'(fast_half - 1);
    localparam logic [SW-1:0]       STEP_TC  = SW'(breath_step - 1);
    localparam logic [BW-1:0]       BW_ONE   = 1;
    localparam logic [SW-1:0]       SW_ONE   = 1;
    localparam logic [pwm_bits-1:0] PWM_ONE  = 1;
    localparam logic [pwm_bits-1:0] DUTY_MAX = {pwm_bits{1'b1}};

    typedef enum logic [2:0] {
        M_OFF    = 3'd0,
        M_ON     = 3'd1,
        M_SLOW   = 3'd2,
        M_FAST   = 3'd3,
        M_BREATH = 3'd4
    } mode_t;

    mode_t               state_q, state_d;
    logic                press_d_q;
    logic                led_q, led_d;
    logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
    logic                phase_q, phase_d;
    logic [pwm_bits-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [pwm_bits-1:0] duty_q, duty_d;
    logic                dir_dn_q, dir_dn_d;
    logic [SW-1:0]       step_cnt_q, step_cnt_d;

    logic                adv;
    logic                mode_chg;
    logic [BW-1:0]       blink_tc;

    assign adv      = press & ~press_d_q;
    assign mode_chg = (state_d != state_q);
    assign blink_tc = (state_q == M_SLOW) ? SLOW_TC : FAST_TC;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= M_OFF;
            press_d_q   <= 1'b0;
            led_q       <= 1'b0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            pwm_cnt_q   <= '0;
            duty_q      <= '0;
            dir_dn_q    <= 1'b0;
            step_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            press_d_q   <= press;
            led_q       <= led_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            pwm_cnt_q   <= pwm_cnt_d;
            duty_q      <= duty_d;
            dir_dn_q    <= dir_dn_d;
            step_cnt_q  <= step_cnt_d;
        end
    end

    // Illegal codes fall back to OFF regardless of press.
    always_comb begin
        state_d = state_q;
        case (state_q)
            M_OFF:    if (adv) state_d = M_ON;
            M_ON:     if (adv) state_d = M_SLOW;
            M_SLOW:   if (adv) state_d = M_FAST;
            M_FAST:   if (adv) state_d = M_BREATH;
            M_BREATH: if (adv) state_d = M_OFF;
            default:  state_d = M_OFF;
        endcase
    end

    // A mode change overrides any terminal count landing on the same edge.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        pwm_cnt_d   = pwm_cnt_q;
        duty_d      = duty_q;
        dir_dn_d    = dir_dn_q;
        step_cnt_d  = step_cnt_q;
        if (mode_chg) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
            pwm_cnt_d   = '0;
            duty_d      = '0;
            dir_dn_d    = 1'b0;
            step_cnt_d  = '0;
        end else begin
            case (state_q)
                M_SLOW, M_FAST: begin
                    if (blink_cnt_q == blink_tc) begin
                        blink_cnt_d = '0;
                        phase_d     = ~phase_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + BW_ONE;
                    end
                end
                M_BREATH: begin
                    pwm_cnt_d = pwm_cnt_q + PWM_ONE;
                    if (step_cnt_q == STEP_TC) begin
                        step_cnt_d = '0;
                        if (!dir_dn_q) begin
                            if (duty_q != DUTY_MAX) begin
                                duty_d = duty_q + PWM_ONE;
                            end else begin
                                dir_dn_d = 1'b1;
                                duty_d   = DUTY_MAX - PWM_ONE;
                            end
                        end else begin
                            if (duty_q != '0) begin
                                duty_d = duty_q - PWM_ONE;
                            end else begin
                                dir_dn_d = 1'b0;
                                duty_d   = PWM_ONE;
                            end
                        end
                    end else begin
                        step_cnt_d = step_cnt_q + SW_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        led_d = 1'b0;
        case (state_q)
            M_OFF:          led_d = 1'b0;
            M_ON:           led_d = 1'b1;
            M_SLOW, M_FAST: led_d = phase_q;
            M_BREATH:       led_d = (pwm_cnt_q < duty_q);
            default:        led_d = 1'b0;
        endcase
    end

    assign led  = led_q;
    assign mode = state_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Bench for led_mode_ctrl: directed scenarios plus random press/reset traffic,
// checked every cycle against a model that derives led from mode and time-in-mode.
module tb_led_mode_ctrl;

    localparam int SH  = 4;
    localparam int FH  = 2;
    localparam int PB  = 3;
    localparam int BS  = 2;
    localparam int MAX = (1 << PB) - 1;

    logic       clk;
    logic       rst;
    logic       press;
    logic       led;
    logic [2:0] mode;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    int m_mode  = 0;
    int m_entry = 0;
    int m_prev  = 0;
    int m_led   = 0;

    led_mode_ctrl #(
        .slow_half  (SH),
        .fast_half  (FH),
        .pwm_bits   (PB),
        .breath_step(BS)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .press(press),
        .led  (led),
        .mode (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, obs, expv, cyc);
        end
    endtask

    // led registered at an edge, given the mode held before it and the edges elapsed since entry.
    function automatic int exp_led(input int md, input int age);
        int r;
        int duty;
        case (md)
            0: return 0;
            1: return 1;
            2: return (age / SH) % 2;
            3: return (age / FH) % 2;
            4: begin
                r    = (age / BS) % (2 * MAX);
                duty = (r <= MAX) ? r : (2 * MAX - r);
                return ((age % (MAX + 1)) < duty) ? 1 : 0;
            end
            default: return 0;
        endcase
    endfunction

    task automatic step(input logic r, input logic p);
        rst   = r;
        press = p;
        @(posedge clk);
        cyc++;
        if (r) begin
            m_led   = 0;
            m_mode  = 0;
            m_prev  = 0;
            m_entry = cyc;
        end else begin
            m_led = exp_led(m_mode, cyc - 1 - m_entry);
            if (p && (m_prev == 0)) begin
                m_mode  = (m_mode + 1) % 5;
                m_entry = cyc;
            end
            m_prev = p ? 1 : 0;
        end
        #1;
        check("mode", mode, m_mode);
        check("led", led, m_led);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic tap;
        step(1'b0, 1'b1);
    endtask

    int hold;

    initial begin
        rst   = 1'b1;
        press = 1'b1;

        // reset dominates a held press
        repeat (3) step(1'b1, 1'b1);
        idle(2);

        // held press advances exactly once
        repeat (10) step(1'b0, 1'b1);
        idle(2);

        // slow then fast blink
        tap();
        idle(16);
        tap();
        idle(8);

        // full breath ramp up and down
        tap();
        idle(40);

        // wrap back to OFF, then walk to SLOW
        tap();
        idle(1);
        tap();
        idle(1);
        tap();
        // press lands on the blink terminal count
        idle(3);
        tap();
        idle(8);
        check("coincident_mode", mode, 3);

        // fifth press from BREATH returns to OFF
        tap();
        idle(6);
        tap();
        idle(1);
        check("wrap_mode", mode, 0);

        // reset mid-breath at duty 5
        tap(); idle(1);
        tap(); idle(1);
        tap(); idle(1);
        tap();
        idle(10);
        step(1'b1, 1'b0);
        check("rst_breath_mode", mode, 0);
        idle(1);
        tap();
        idle(1);
        check("after_rst_mode", mode, 1);

        // random press bursts with occasional reset
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            logic r;
            logic p;
            r = ($urandom_range(0, 299) == 0);
            if (hold > 0) begin
                p = 1'b1;
                hold--;
            end else if ($urandom_range(0, 15) == 0) begin
                hold = $urandom_range(0, 3);
                p    = 1'b1;
            end else begin
                p = 1'b0;
            end
            step(r, p);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
